// File: rtl/AHB_package.sv
// AHB-lite bus bundles shared by renas masters and slaves.
// mas_send_type: master request; slv_send_type: slave response.
package AHB_package;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
  } mas_send_type;

  typedef struct packed {
    logic        hreadyout;
    logic [31:0] hrdata;
  } slv_send_type;

endpackage

// File: rtl/RVS192_package.sv
// Shared RVS192 definitions: refill FSM states and line geometry.
// LINE_OFFSET_BITS is the byte-offset width of a default cache line.
package RVS192_package;

  localparam int REFILL_WORDS_PER_LINE = 4;
  localparam int LINE_OFFSET_BITS =
    $clog2(REFILL_WORDS_PER_LINE) + 2;

  typedef enum logic [2:0] {
    RF_IDLE,
    RF_WB_REQ,
    RF_WB_GAP,
    RF_RD_REQ,
    RF_RD_GAP,
    RF_DONE
  } refill_state_type;

endpackage

// File: rtl/refill_line_buffer.sv
// WORDS x 32-bit line buffer: indexed word write, flat read-out.
// Ports: clk_l2, clr (sync clear), wr_en/wr_idx/wr_data, line.
module refill_line_buffer #(
  parameter int WORDS = 4
) (
  input  logic                     clk_l2,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(WORDS)-1:0] wr_idx,
  input  logic [31:0]              wr_data,
  output logic [32*WORDS-1:0]      line
);

  localparam int IW = $clog2(WORDS);

  always_ff @(posedge clk_l2) begin
    if (clr) begin
      line <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (wr_en && wr_idx == IW'(i))
          line[32*i +: 32] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/renas_line_refill.sv
// Line refill / victim write-back engine, L2 <-> renas memory D-side AHB.
// In: clk_l2, rst, miss_req/miss_addr, wb_valid/wb_addr/wb_line, mem_in.
// Out: busy, refill_done, refill_line, mem_hsel, mem_out.
// REFILL_CRITICAL_WORD_FIRST_EN: rotate reads to the missing word first,
// adds crit_valid/crit_word.
module renas_line_refill
  import RVS192_package::*;
  import AHB_package::*;
#(
  parameter int WORDS_PER_LINE = REFILL_WORDS_PER_LINE,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                        clk_l2,
  input  logic                        rst,
  input  logic                        miss_req,
  input  logic [31:0]                 miss_addr,
  input  logic                        wb_valid,
  input  logic [31:0]                 wb_addr,
  input  logic [32*WORDS_PER_LINE-1:0] wb_line,
  output logic                        busy,
  output logic                        refill_done,
  output logic [32*WORDS_PER_LINE-1:0] refill_line,
  output logic                        mem_hsel,
  output mas_send_type                mem_out,
  input  slv_send_type                mem_in
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  ,
  output logic                        crit_valid,
  output logic [31:0]                 crit_word
`endif
);

  localparam int IW  = $clog2(WORDS_PER_LINE);
  localparam int OFF = LINE_OFFSET_BITS + IW
                     - $clog2(REFILL_WORDS_PER_LINE);
  localparam int GW  = $clog2(GAP_CYCLES);
  localparam logic [IW-1:0] LAST  = IW'(WORDS_PER_LINE - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  refill_state_type state;

  logic [IW-1:0]    cnt;
  logic [IW-1:0]    cnt_nx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    rd_idx_nx;
  logic [IW-1:0]    idle_first;
  logic [IW-1:0]    rd_first;
  logic [GW-1:0]    gcnt;
  logic [31-OFF:0]  line_hi;
  logic [31-OFF:0]  wb_hi;
  logic [32*WORDS_PER_LINE-1:0] wb_buf;
  logic             wr_en;
  logic             unused_bits;

  assign cnt_nx = cnt + IW'(1);

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic [IW-1:0] crit;
  assign rd_idx     = crit + cnt;
  assign rd_idx_nx  = crit + cnt_nx;
  assign idle_first = miss_addr[OFF-1:2];
  assign rd_first   = crit;
`else
  assign rd_idx     = cnt;
  assign rd_idx_nx  = cnt_nx;
  assign idle_first = '0;
  assign rd_first   = '0;
`endif

  assign unused_bits = ^{miss_addr[OFF-1:0], wb_addr[OFF-1:0]};

  // Ready is only meaningful while a read request is on the bus.
  assign wr_en = (state == RF_RD_REQ) && mem_in.hreadyout && !rst;

  function automatic logic [31:0] word_addr(
    input logic [31-OFF:0] hi,
    input logic [IW-1:0]   i
  );
    return {hi, i, 2'b00};
  endfunction

  function automatic mas_send_type mk_req(
    input logic [31:0] a,
    input logic        w,
    input logic [31:0] d
  );
    mas_send_type r;
    r        = '0;
    r.haddr  = a;
    r.hwrite = w;
    r.hwdata = d;
    r.htrans = HTRANS_NONSEQ;
    r.hsize  = HSIZE_WORD;
    return r;
  endfunction

  always_ff @(posedge clk_l2) begin
    if (rst) begin
      state       <= RF_IDLE;
      cnt         <= '0;
      gcnt        <= '0;
      busy        <= 1'b0;
      refill_done <= 1'b0;
      mem_hsel    <= 1'b0;
      mem_out     <= '0;
      line_hi     <= '0;
      wb_hi       <= '0;
      wb_buf      <= '0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
      crit        <= '0;
      crit_valid  <= 1'b0;
      crit_word   <= '0;
`endif
    end else begin
      refill_done <= 1'b0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
      crit_valid  <= 1'b0;
`endif
      unique case (state)
        RF_IDLE: begin
          if (miss_req) begin
            line_hi  <= miss_addr[31:OFF];
            wb_hi    <= wb_addr[31:OFF];
            wb_buf   <= wb_line;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
            crit     <= idle_first;
`endif
            cnt      <= '0;
            busy     <= 1'b1;
            mem_hsel <= 1'b1;
            if (wb_valid) begin
              state   <= RF_WB_REQ;
              mem_out <= mk_req(word_addr(wb_addr[31:OFF], '0),
                                1'b1, wb_line[31:0]);
            end else begin
              state   <= RF_RD_REQ;
              mem_out <= mk_req(word_addr(miss_addr[31:OFF],
                                          idle_first),
                                1'b0, 32'h0);
            end
          end
        end
        RF_WB_REQ, RF_RD_REQ: begin
          if (mem_in.hreadyout) begin
            state    <= (state == RF_WB_REQ) ? RF_WB_GAP
                                             : RF_RD_GAP;
            gcnt     <= '0;
            mem_hsel <= 1'b0;
            mem_out  <= '0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
            if (state == RF_RD_REQ && cnt == '0) begin
              crit_valid <= 1'b1;
              crit_word  <= mem_in.hrdata;
            end
`endif
          end
        end
        RF_WB_GAP, RF_RD_GAP: begin
          if (gcnt != GLAST) begin
            gcnt <= gcnt + GW'(1);
          end else begin
            // cnt_nx wraps to zero after the last word.
            cnt      <= cnt_nx;
            mem_hsel <= 1'b1;
            if (state == RF_WB_GAP) begin
              if (cnt == LAST) begin
                state   <= RF_RD_REQ;
                mem_out <= mk_req(word_addr(line_hi, rd_first),
                                  1'b0, 32'h0);
              end else begin
                state   <= RF_WB_REQ;
                mem_out <= mk_req(word_addr(wb_hi, cnt_nx), 1'b1,
                                  wb_buf[{cnt_nx, 5'd0} +: 32]);
              end
            end else if (cnt == LAST) begin
              state       <= RF_DONE;
              mem_hsel    <= 1'b0;
              refill_done <= 1'b1;
            end else begin
              state   <= RF_RD_REQ;
              mem_out <= mk_req(word_addr(line_hi, rd_idx_nx),
                                1'b0, 32'h0);
            end
          end
        end
        RF_DONE: begin
          state <= RF_IDLE;
          busy  <= 1'b0;
        end
        default: state <= RF_IDLE;
      endcase
    end
  end

  // A reset while busy keeps the partial line; an idle reset clears it.
  refill_line_buffer #(
    .WORDS(WORDS_PER_LINE)
  ) u_buf (
    .clk_l2  (clk_l2),
    .clr     (rst && !busy),
    .wr_en   (wr_en),
    .wr_idx  (rd_idx),
    .wr_data (mem_in.hrdata),
    .line    (refill_line)
  );

endmodule

// File: doc/renas_line_refill.md
# renas_line_refill

Line-refill/write-back engine between the L2 cache controller and the renas main memory's D-side AHB port. On a cache miss it optionally writes back a dirty victim line word by word, then fetches the missing line word by word. Each transfer uses the memory's hold-until-ready single-word handshake, and the engine returns the assembled line to the cache. It runs in the `clk_l2` domain.

## Interface
- `WORDS_PER_LINE`, 4: 32-bit words per cache line; power of two, 2..16.
- `GAP_CYCLES`, 2: idle cycles with `mem_hsel` low after each completed transfer; minimum 2.
- `clk_l2` input 1: sole clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `miss_req` input 1: start request; sampled only in IDLE.
- `miss_addr` input 32: missing byte address; bits [1:0] ignored.
- `wb_valid` input 1: victim is dirty; sampled with `miss_req`.
- `wb_addr` input 32: victim line base address.
- `wb_line` input 32*WORDS_PER_LINE: victim data; word i at bits [32i+31:32i].
- `busy` output 1: high in every state except IDLE.
- `refill_done` output 1: one-cycle pulse when `refill_line` is valid.
- `refill_line` output 32*WORDS_PER_LINE: fetched line, same word packing as `wb_line`.
- `mem_hsel` output 1: transfer select toward memory.
- `mem_out` output mas_send_type: haddr, hwrite, hwdata, htrans, hsize.
- `mem_in` input slv_send_type: hreadyout, hrdata.

## Operation
- **Request capture.** In IDLE, `miss_req=1` latches the following:
  - `miss_addr` line base (low log2(WORDS_PER_LINE)+2 bits cleared) and critical word index.
  - `wb_valid`, `wb_addr` and `wb_line`.
  - Cache inputs are don't-care afterwards.
- **FSM states.** IDLE, WB_REQ, WB_GAP, RD_REQ, RD_GAP, DONE.
- **IDLE exit.** Goes to WB_REQ if the latched `wb_valid` is 1, otherwise to RD_REQ. Word counter `cnt` is cleared.
- **WB_REQ.**
  - Drives `mem_hsel=1`, `hwrite=1`, `haddr=wb_base+4*cnt`, `hwdata=word[cnt]`, `htrans=NONSEQ`, `hsize=word`.
  - All of these stay stable until `hreadyout=1` is sampled, then the FSM goes to WB_GAP.
- **WB_GAP.**
  - `mem_hsel=0`, `htrans=IDLE`; waits GAP_CYCLES.
  - Then `cnt` is incremented. If `cnt` was WORDS_PER_LINE-1, `cnt` is cleared and the FSM goes to RD_REQ; otherwise it returns to WB_REQ.
- **RD_REQ.** Same as WB_REQ but `hwrite=0` and `hwdata=0`. On `hreadyout=1`, `hrdata` is stored into line buffer word `idx`, then the FSM goes to RD_GAP.
- **RD_GAP.** Same as WB_GAP, but after the last word the FSM goes to DONE.
- **DONE.** `refill_done=1` for one cycle, then IDLE. `refill_line` holds its value until the next refill writes into it.
- **Word index.** `idx = cnt` by default; see Configuration. `haddr = line_base + 4*idx`. The index wraps modulo WORDS_PER_LINE, so the address never leaves the line.
- **Unexpected ready.** `hreadyout` seen while `mem_hsel=0` (GAP or IDLE) is ignored; no data is captured.
- **No abort.** `miss_req` while `busy=1` is ignored; the requester must wait for `refill_done`.
- **Reset mid-transfer.**
  - Returns to IDLE within one cycle; `mem_hsel` and `busy` go low on the next edge. The outstanding memory transaction is abandoned.
  - `refill_line` keeps its partial content but `refill_done` is not asserted.

## Timing
- **Reset values.** `busy=0`, `refill_done=0`, `refill_line=0`, `mem_hsel=0`, `mem_out=0` (htrans=IDLE), FSM=IDLE, `cnt=0`.
- **Start.** `miss_req` at edge N → `busy` and `mem_hsel` high from edge N+1.
- **Handshake.** `hreadyout` is sampled every cycle in a REQ state, and memory latency is unbounded. Hold-until-ready plus the gap guarantees the memory's request flag clears before the next select.
- **Per-word cost.** Memory latency L plus GAP_CYCLES.
- **Total latency.** (1 + wb_valid) × WORDS_PER_LINE × (L + GAP_CYCLES) + 2 cycles from `miss_req` to `refill_done`.
- **`refill_done` alignment.** Rises one cycle after the last RD_GAP ends; `refill_line` is already valid in that cycle.

## Configuration
- **`REFILL_CRITICAL_WORD_FIRST_EN` defined.**
  - Read phase uses `idx = (crit + cnt) mod WORDS_PER_LINE`, so the missing word is fetched first.
  - Adds output `crit_valid`, a one-cycle pulse when the critical word is stored, with `crit_word` (32 bits) holding that word.
- **Undefined.**
  - `idx = cnt`, so reads start at word 0.
  - `crit_valid` and `crit_word` ports are absent.
- The write-back phase is always in ascending order.

## Structure
- **Shared package (RVS192_package).** Add:
  - `refill_state_type` enum.
  - `LINE_OFFSET_BITS` = log2(WORDS_PER_LINE)+2.
- **Bus types.** `mas_send_type` and `slv_send_type` come from AHB_package and are not redefined.
- **Sub-module.** `refill_line_buffer`: WORDS_PER_LINE×32 register file with indexed write and flat read-out.

## Test plan
- **Clean miss.** `miss_req`, `miss_addr=0x0000_2014`, `wb_valid=0`, memory L=3 → reads at 0x2010, 0x2014, 0x2018, 0x201C in that order; `refill_done` after 4×(3+2)+2=22 cycles; `refill_line` matches memory.
- **Dirty miss.** `wb_valid=1`, `wb_addr=0x0000_1040`, `wb_line={D,C,B,A}` → writes A..D to 0x1040..0x104C with `hwrite=1`, then 4 reads. Memory read-back of 0x1040..0x104C equals A..D.
- **Critical word first.** With `REFILL_CRITICAL_WORD_FIRST_EN`, `miss_addr=0x0000_201C` → reads 0x201C, 0x2010, 0x2014, 0x2018; `crit_valid` pulses after the first read with `crit_word=mem[0x201C]`.
- **Gap enforcement.** After every `hreadyout` pulse, `mem_hsel` is low for ≥GAP_CYCLES and never re-asserts earlier. A spurious `hreadyout` injected during the gap leaves `refill_line` unchanged.
- **Busy/reset.** `miss_req` pulsed while busy → ignored, with exactly one `refill_done`. `rst=1` during the 2nd read → next cycle `busy=0`, `mem_hsel=0`, no `refill_done`; a new miss afterwards completes normally.
